// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

  localparam int SPI_WIDTH = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_slave16_if.sv
// SPI pin bundle plus the parallel side of the responder.
// The master modport is the link master / bench; the slave modport is spi_slave16.
interface spi_slave16_if
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
);
  logic             SS_n;
  logic             SCLK;
  logic             MOSI;
  logic             MISO;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             rdy;
  logic             clr_rdy;
  logic             frm_err;

  modport master (
    output SS_n, SCLK, MOSI, tx_data, clr_rdy,
    input  MISO, rx_data, rdy, frm_err
  );

  modport slave (
    input  SS_n, SCLK, MOSI, tx_data, clr_rdy,
    output MISO, rx_data, rdy, frm_err
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizer plus history flop for one asynchronous SPI pin.
// All flops reset to 1 so an idle (high) bus produces no edge out of reset.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Metastability chain followed by one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~hist_q;
  assign fall_o = ~sync_o & hist_q;

endmodule

// File: rtl/spi_slave16.sv
// SPI mode-3 responder: shifts in a WIDTH-bit command MSB first, shifts out
// tx_data, flags rdy on a complete frame and frm_err on a wrong-length frame.
// Optional macro SPI_SLV_TRISTATE_EN: float MISO while deselected.
module spi_slave16
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_slave16_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 2);

  logic ss_s, ss_rise, ss_fall;
  logic sclk_rise, sclk_fall, sclk_s_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_state_t       state_q, state_d;
  logic [WIDTH-1:0] tx_shft_q, tx_shft_d;
  logic [WIDTH-1:0] rx_shft_q, rx_shft_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             first_q, first_d;
  logic             rdy_q, rdy_d;
  logic             frm_err_q, frm_err_d;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .rst_n(rst_n), .d_i(bus.SS_n),
    .sync_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(bus.SCLK),
    .sync_o(sclk_s_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(bus.MOSI),
    .sync_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_shft_q <= '0;
      rx_shft_q <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      first_q   <= 1'b0;
      rdy_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_shft_q <= tx_shft_d;
      rx_shft_q <= rx_shft_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      first_q   <= first_d;
      rdy_q     <= rdy_d;
      frm_err_q <= frm_err_d;
    end
  end

  // Frame FSM: load on select, shift on SCLK edges, judge length on deselect.
  // The frame-complete set of rdy is assigned after the clear so it wins.
  always_comb begin
    state_d   = state_q;
    tx_shft_d = tx_shft_q;
    rx_shft_d = rx_shft_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    first_d   = first_q;
    rdy_d     = rdy_q & ~bus.clr_rdy;
    frm_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = ACTIVE;
          tx_shft_d = bus.tx_data;
          rx_shft_d = '0;
          bit_cnt_d = '0;
          first_d   = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == CW'(WIDTH)) begin
            rx_data_d = rx_shft_q;
            rdy_d     = 1'b1;
          end else begin
            frm_err_d = 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            rx_shft_d = {rx_shft_q[WIDTH-2:0], mosi_s};
            if (bit_cnt_q != CW'(WIDTH + 1)) bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (sclk_fall) begin
            // The first falling edge only opens the frame; the MSB is already out.
            if (first_q) first_d   = 1'b0;
            else         tx_shft_d = {tx_shft_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_SLV_TRISTATE_EN
  assign bus.MISO = ss_s ? 1'bz : tx_shft_q[WIDTH-1];
`else
  assign bus.MISO = ss_s ? 1'b1 : tx_shft_q[WIDTH-1];
`endif

  assign bus.rx_data = rx_data_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_err_q;

endmodule

// File: tb/tb_spi_slave16.sv
// Directed bench for spi_slave16: acts as a mode-3 SPI master with SCLK at clk/16.
module tb_spi_slave16;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   nfail = 0;
  int   err_pulses = 0;
  logic miso_idle;

  always #5 clk = ~clk;

  spi_slave16_if #(.WIDTH(16)) bus();

  spi_slave16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Counts clocks with frm_err high; a single 1-clk pulse adds exactly one.
  always @(posedge clk) if (bus.frm_err === 1'b1) err_pulses <= err_pulses + 1;

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Select, then n SCLK cycles (falling edge drives MOSI, rising edge samples MISO).
  // Leaves SS_n low so the caller controls the deselect timing.
  task automatic frame_bits(input logic [15:0] cmd, input logic [15:0] tx, input int n,
                            output logic [15:0] rd);
    rd = '0;
    bus.tx_data = tx;
    bus.SS_n = 1'b0;
    clks(8);
    for (int i = 0; i < n; i++) begin
      bus.SCLK = 1'b0;
      bus.MOSI = (i < 16) ? cmd[15 - i] : 1'b0;
      clks(8);
      bus.SCLK = 1'b1;
      rd = {rd[14:0], bus.MISO};
      clks(8);
    end
  endtask

  task automatic end_frame();
    bus.SS_n = 1'b1;
    clks(8);
  endtask

  task automatic pulse_clr();
    bus.clr_rdy = 1'b1;
    clks(1);
    bus.clr_rdy = 1'b0;
    clks(1);
  endtask

  task automatic test_reset();
    clks(3);
    nchk++; if (bus.rx_data !== 16'h0000) begin nfail++; $display("FAIL reset_rx_data: got %h want 0000", bus.rx_data); end
    nchk++; if (bus.rdy !== 1'b0) begin nfail++; $display("FAIL reset_rdy: got %b want 0", bus.rdy); end
    nchk++; if (bus.frm_err !== 1'b0) begin nfail++; $display("FAIL reset_frm_err: got %b want 0", bus.frm_err); end
    nchk++; if (bus.MISO !== miso_idle) begin nfail++; $display("FAIL reset_miso_idle: got %b want %b", bus.MISO, miso_idle); end
    rst_n = 1'b1;
    clks(4);
  endtask

  task automatic test_basic();
    logic [15:0] rd;
    int e0;
    e0 = err_pulses;
    frame_bits(16'hA5C3, 16'h1234, 16, rd);
    end_frame();
    nchk++; if (bus.rx_data !== 16'hA5C3) begin nfail++; $display("FAIL basic_rx_data: got %h want a5c3", bus.rx_data); end
    nchk++; if (bus.rdy !== 1'b1) begin nfail++; $display("FAIL basic_rdy: got %b want 1", bus.rdy); end
    nchk++; if (rd !== 16'h1234) begin nfail++; $display("FAIL basic_miso_word: got %h want 1234", rd); end
    nchk++; if (err_pulses - e0 !== 0) begin nfail++; $display("FAIL basic_no_err: got %0d pulses want 0", err_pulses - e0); end
    nchk++; if (bus.MISO !== miso_idle) begin nfail++; $display("FAIL basic_miso_idle: got %b want %b", bus.MISO, miso_idle); end
    pulse_clr();
    nchk++; if (bus.rdy !== 1'b0) begin nfail++; $display("FAIL basic_clr_rdy: got %b want 0", bus.rdy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd;
    int e0;
    e0 = err_pulses;
    frame_bits(16'h0001, 16'h0000, 16, rd);
    end_frame();
    nchk++; if (bus.rx_data !== 16'h0001) begin nfail++; $display("FAIL b2b_first_rx: got %h want 0001", bus.rx_data); end
    frame_bits(16'h8000, 16'h0000, 16, rd);
    end_frame();
    nchk++; if (bus.rx_data !== 16'h8000) begin nfail++; $display("FAIL b2b_rx_data: got %h want 8000", bus.rx_data); end
    nchk++; if (bus.rdy !== 1'b1) begin nfail++; $display("FAIL b2b_rdy: got %b want 1", bus.rdy); end
    nchk++; if (err_pulses - e0 !== 0) begin nfail++; $display("FAIL b2b_no_err: got %0d pulses want 0", err_pulses - e0); end
  endtask

  task automatic test_short();
    logic [15:0] rd;
    int e0;
    e0 = err_pulses;
    frame_bits(16'h5555, 16'hFFFF, 9, rd);
    end_frame();
    nchk++; if (err_pulses - e0 !== 1) begin nfail++; $display("FAIL short_frm_err: got %0d pulses want 1", err_pulses - e0); end
    nchk++; if (bus.rx_data !== 16'h8000) begin nfail++; $display("FAIL short_rx_kept: got %h want 8000", bus.rx_data); end
    nchk++; if (bus.rdy !== 1'b1) begin nfail++; $display("FAIL short_rdy_kept: got %b want 1", bus.rdy); end
  endtask

  task automatic test_overrun();
    logic [15:0] rd;
    int e0;
    e0 = err_pulses;
    frame_bits(16'hFFFF, 16'h0000, 19, rd);
    nchk++; if (dut.bit_cnt_q !== 5'd17) begin nfail++; $display("FAIL overrun_cnt_sat: got %0d want 17", dut.bit_cnt_q); end
    end_frame();
    nchk++; if (err_pulses - e0 !== 1) begin nfail++; $display("FAIL overrun_frm_err: got %0d pulses want 1", err_pulses - e0); end
    nchk++; if (bus.rx_data !== 16'h8000) begin nfail++; $display("FAIL overrun_rx_kept: got %h want 8000", bus.rx_data); end
    nchk++; if (bus.rdy !== 1'b1) begin nfail++; $display("FAIL overrun_rdy_kept: got %b want 1", bus.rdy); end
  endtask

  // SS_n rise reaches the FSM 3 clks after the pin; clr_rdy is lined up with that clk.
  task automatic test_clr_collision();
    logic [15:0] rd;
    pulse_clr();
    nchk++; if (bus.rdy !== 1'b0) begin nfail++; $display("FAIL coll_pre_clear: got %b want 0", bus.rdy); end
    frame_bits(16'h3C3C, 16'h0000, 16, rd);
    bus.SS_n = 1'b1;
    clks(2);
    bus.clr_rdy = 1'b1;
    clks(1);
    bus.clr_rdy = 1'b0;
    nchk++; if (bus.rdy !== 1'b1) begin nfail++; $display("FAIL coll_set_wins: got %b want 1", bus.rdy); end
    nchk++; if (bus.rx_data !== 16'h3C3C) begin nfail++; $display("FAIL coll_rx_data: got %h want 3c3c", bus.rx_data); end
    clks(1);
    bus.clr_rdy = 1'b1;
    clks(1);
    bus.clr_rdy = 1'b0;
    nchk++; if (bus.rdy !== 1'b0) begin nfail++; $display("FAIL coll_late_clr: got %b want 0", bus.rdy); end
    clks(6);
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    int e0;
    frame_bits(16'hAAAA, 16'h0000, 8, rd);
    rst_n = 1'b0;
    clks(1);
    nchk++; if (bus.rx_data !== 16'h0000) begin nfail++; $display("FAIL rstmid_rx_data: got %h want 0000", bus.rx_data); end
    nchk++; if (dut.bit_cnt_q !== 5'd0) begin nfail++; $display("FAIL rstmid_bit_cnt: got %0d want 0", dut.bit_cnt_q); end
    bus.SS_n = 1'b1;
    clks(2);
    rst_n = 1'b1;
    clks(6);
    e0 = err_pulses;
    frame_bits(16'hFFFF, 16'h0000, 16, rd);
    end_frame();
    nchk++; if (bus.rx_data !== 16'hFFFF) begin nfail++; $display("FAIL rstmid_rx_ffff: got %h want ffff", bus.rx_data); end
    nchk++; if (bus.rdy !== 1'b1) begin nfail++; $display("FAIL rstmid_rdy: got %b want 1", bus.rdy); end
    nchk++; if (err_pulses - e0 !== 0) begin nfail++; $display("FAIL rstmid_no_err: got %0d pulses want 0", err_pulses - e0); end
  endtask

  initial begin
`ifdef SPI_SLV_TRISTATE_EN
    miso_idle = 1'bz;
`else
    miso_idle = 1'b1;
`endif
    bus.SS_n    = 1'b1;
    bus.SCLK    = 1'b1;
    bus.MOSI    = 1'b1;
    bus.tx_data = 16'h0000;
    bus.clr_rdy = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_short();
    test_overrun();
    test_clr_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
